// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop decoding,
// runtime baud divisor, valid/ready delivery with sticky overrun flag.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit voting
// around mid-bit instead of a single mid-bit sample.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rx_en,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DEC_PT = OVERSAMPLE / 2;
`else
  localparam int unsigned DEC_PT = OVERSAMPLE / 2 - 1;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_m, rxd_s;
  logic [DIV_W-1:0]     div_cnt, baud_q, div_reload_c;
  logic [CNT_W-1:0]     samp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [1:0]           parity_q;
  logic                 two_stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic                 tick_c, decide_c, bit_c, par_en_c, exp_par_c;
  logic                 start_c, done_c;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Sample-tick down-counter; uses the live divisor only while idle
  assign div_reload_c = (state_q == IDLE) ? baud_div : baud_q;
  assign tick_c       = rx_en && (div_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!rx_en || div_cnt == '0) begin
      div_cnt <= div_reload_c;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote_a, vote_b;

  // Capture the two samples preceding the decision point for the vote
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick_c && state_q != IDLE) begin
      if (samp_cnt == CNT_W'(DEC_PT - 2)) vote_a <= rxd_s;
      if (samp_cnt == CNT_W'(DEC_PT - 1)) vote_b <= rxd_s;
    end
  end

  assign bit_c = (vote_a & vote_b) | (vote_a & rxd_s) | (vote_b & rxd_s);
`else
  assign bit_c = rxd_s;
`endif

  assign decide_c  = tick_c && (state_q != IDLE) && (samp_cnt == CNT_W'(DEC_PT));
  assign par_en_c  = (parity_q == 2'b01) || (parity_q == 2'b10);
  assign exp_par_c = (parity_q == 2'b01) ? (^shift_q) : ~(^shift_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and per-frame strobes
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c && !rxd_s) begin
          state_d = START;
          start_c = 1'b1;
        end
      end
      START: begin
        if (decide_c) state_d = bit_c ? IDLE : DATA;
      end
      DATA: begin
        if (decide_c && bit_cnt == BIT_W'(DATA_BITS - 1))
          state_d = par_en_c ? PARITY : STOP;
      end
      PARITY: begin
        if (decide_c) state_d = STOP;
      end
      STOP: begin
        if (decide_c && (!two_stop_q || bit_cnt == BIT_W'(1))) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d = IDLE;
      start_c = 1'b0;
      done_c  = 1'b0;
    end
  end

  // Frame datapath: counters, configuration latch, shift register, error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      baud_q     <= '0;
      parity_q   <= 2'b00;
      two_stop_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (start_c) begin
        samp_cnt   <= '0;
        baud_q     <= baud_div;
        parity_q   <= parity_mode;
        two_stop_q <= two_stop;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end else if (tick_c && state_q != IDLE) begin
        samp_cnt <= samp_cnt + CNT_W'(1);
      end

      if (state_d != state_q)                            bit_cnt <= '0;
      else if (decide_c && (state_q == DATA || state_q == STOP)) bit_cnt <= bit_cnt + BIT_W'(1);

      if (decide_c && state_q == DATA)   shift_q <= {bit_c, shift_q[DATA_BITS-1:1]};
      if (decide_c && state_q == PARITY) perr_q  <= (bit_c != exp_par_c);
      if (decide_c && state_q == STOP && !bit_c) ferr_q <= 1'b1;
    end
  end

  // Delivery registers and valid/ready handshake with sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_perror  <= 1'b0;
      rx_ferror  <= 1'b0;
      rx_overrun <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (done_c) begin
        rx_data   <= shift_q;
        rx_perror <= perr_q;
        rx_ferror <= ferr_q | ~bit_c;
        rx_valid  <= 1'b1;
        if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
        else if (rx_valid)         rx_overrun <= 1'b0;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus randomized
// frames; expected words go into a queue, a monitor pops on each handshake.
module tb_uart_rx_param;

  localparam int OS    = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       parity_mode = 2'b00;
  logic             two_stop = 1'b0;
  logic             rx_en = 1'b1;
  logic             rxd = 1'b1;
  logic             rx_ready = 1'b1;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_perror, rx_ferror, rx_overrun, busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   hs_prev = 1'b0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .rx_en(rx_en), .rxd(rxd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perror(rx_perror),
    .rx_ferror(rx_ferror), .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; the expected word is derived from the bits actually sent.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pm, input logic ts,
                            input logic par_bit, input logic stop1, input logic stop2,
                            input int bd, input bit push, input bit ovr, input bit scramble);
    int   per;
    logic pe, exp_par;
    exp_t e;
    per     = OS * (bd + 1);
    pe      = (pm == 2'b01) || (pm == 2'b10);
    exp_par = (pm == 2'b01) ? ^data : ~^data;
    baud_div = DIV_W'(bd);
    parity_mode = pm;
    two_stop = ts;
    step(4);
    e.data = data;
    e.perr = pe && (par_bit != exp_par);
    e.ferr = !stop1 || (ts && !stop2);
    e.ovr  = ovr;
    if (push) exp_q.push_back(e);
    rxd = 1'b0;
    step(per);
    if (scramble) begin
      parity_mode = 2'($urandom);
      two_stop    = 1'($urandom);
      baud_div    = DIV_W'($urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      step(per);
    end
    if (pe) begin
      rxd = par_bit;
      step(per);
    end
    if (ts) begin
      rxd = stop1;
      step(per);
      rxd = stop2;
    end else begin
      rxd = stop1;
    end
    if (rxd) step(per);
    else     step(per * 3 / 4);
    rxd = 1'b1;
    step(2 * per + 64);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step(1);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, busy, 1'b0);
  endtask

  // Scoreboard monitor: compare each handshaken word with the queue head
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        check("post_hs_valid", rx_valid, 1'b0);
        check("post_hs_overrun", rx_overrun, 1'b0);
      end
      hs_prev = rx_valid && rx_ready;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_data", rx_data, mon_e.data);
          check("rx_perror", rx_perror, mon_e.perr);
          check("rx_ferror", rx_ferror, mon_e.ferr);
          check("rx_overrun", rx_overrun, mon_e.ovr);
        end
      end
    end
  end

  initial begin
    bit seen;
    step(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_flags", {rx_perror, rx_ferror, rx_overrun}, 3'b000);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(5);

    // Basic frame, no parity, one stop bit
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    drain("t1");

    // Even parity: wrong then correct parity bit
    send_frame(8'h37, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    send_frame(8'h37, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0);
    drain("t2");

    // Two stop bits: second low, then both high
    send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0);
    send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    drain("t3");

    // False start: short low pulse must not produce a word
    baud_div = '0;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) seen = 1'b1;
      step(1);
    end
    check("t4_busy_pulse", seen, 1'b1);
    check("t4_busy_idle", busy, 1'b0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    drain("t4");

    // Overrun: two words without acceptance, then a one-clk ready pulse
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1, 0);
    check("t5_valid_held", rx_valid, 1'b1);
    check("t5_data", rx_data, 8'h22);
    check("t5_overrun", rx_overrun, 1'b1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(2);
    check("t5_valid_cleared", rx_valid, 1'b0);
    rx_ready = 1'b1;
    drain("t5");

    // rx_en abort mid-frame discards the partial word
    rxd = 1'b0;
    step(OS * 3);
    rx_en = 1'b0;
    step(2);
    check("t6_abort_busy", busy, 1'b0);
    rxd = 1'b1;
    step(5);
    rx_en = 1'b1;
    step(40);
    check("t6_no_valid", rx_valid, 1'b0);

    // Asynchronous reset during data bit 3 of 0xFF
    rxd = 1'b0;
    step(OS);
    rxd = 1'b1;
    step(3 * OS + 5);
    check("t7_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t7_rst_valid", rx_valid, 1'b0);
    check("t7_rst_data", rx_data, 8'h00);
    check("t7_rst_flags", {rx_perror, rx_ferror, rx_overrun}, 3'b000);
    check("t7_rst_busy", busy, 1'b0);
    step(2);
    reset = 1'b0;
    step(5);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0);
    drain("t7");

`ifdef UART_RX_MAJORITY_EN
    // One-clk low glitch at mid-bit of a 1 data bit is voted out
    baud_div = '0;
    step(4);
    exp_q.push_back('{8'hFF, 1'b0, 1'b0, 1'b0});
    rxd = 1'b0;
    step(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = 1'b1;
      if (i == 2) begin
        step(OS / 2);
        rxd = 1'b0;
        step(1);
        rxd = 1'b1;
        step(OS / 2 - 1);
      end else begin
        step(OS);
      end
    end
    rxd = 1'b1;
    step(3 * OS);
    drain("t8");
`endif

    // Randomized frames with mid-frame configuration changes
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 2), 1, 0, 1);
    end
    drain("rand");

    step(10);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
